// File: rtl/fifo_pkg.sv
// Shared FIFO read-side parameters and the packer state encoding.
package fifo_pkg;

   localparam int unsigned DATA_WIDTH = 8;
   localparam int unsigned ADDR_WIDTH = 4;
   localparam int unsigned BEATS      = 4;

   // Packer states: gathering bytes, or presenting a word to the sink.
   typedef enum logic {
      FILL = 1'b0,
      SEND = 1'b1
   } state_e;

endpackage : fifo_pkg

// File: rtl/fifo_rd_packer.sv
// Pops bytes from a FIFO read port and packs BEATS of them into one wide word,
// first-popped byte in lane 0. A flush emits a partial word with a lane mask.
module fifo_rd_packer
   import fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = fifo_pkg::DATA_WIDTH,
   parameter int unsigned BEATS      = fifo_pkg::BEATS
) (
   input  logic                        rclk,
   input  logic                        rrst,
   input  logic                        rempty,
   input  logic [DATA_WIDTH-1:0]       rdata,
   output logic                        rinc,
   input  logic                        flush,
   output logic [DATA_WIDTH*BEATS-1:0] out_data,
   output logic [BEATS-1:0]            out_keep,
   output logic                        out_valid,
   input  logic                        out_ready
);

   localparam int unsigned CNT_W  = $clog2(BEATS + 1);
   localparam int unsigned WORD_W = DATA_WIDTH * BEATS;

   state_e              state;
   state_e              state_nxt;
   logic [CNT_W-1:0]    cnt;
   logic [CNT_W-1:0]    cnt_nxt;
   logic                pend;
   logic [CNT_W:0]      inflight;
   logic [WORD_W-1:0]   data_nxt;
   logic [BEATS-1:0]    keep_nxt;
   logic                valid_nxt;

   // Lanes already captured plus the pop whose data arrives next cycle.
   assign inflight = (CNT_W+1)'(cnt) + (CNT_W+1)'(pend);

   // Pop while there is room for one more byte; held off by flush, reset and SEND.
   assign rinc = !rrst && (state == FILL) && !rempty && !flush &&
                 (inflight < (CNT_W+1)'(BEATS));

   // Next-state and next-output decode.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      data_nxt  = out_data;
      keep_nxt  = out_keep;
      valid_nxt = out_valid;
      case (state)
         FILL: begin
            if (pend) begin
               // In-flight byte always lands first, even when a flush is pending.
               for (int unsigned i = 0; i < BEATS; i++) begin
                  if (cnt == CNT_W'(i)) begin
                     data_nxt[i*DATA_WIDTH +: DATA_WIDTH] = rdata;
                  end
               end
               cnt_nxt = cnt + CNT_W'(1);
               if (cnt_nxt == CNT_W'(BEATS)) begin
                  state_nxt = SEND;
                  valid_nxt = 1'b1;
                  keep_nxt  = '1;
               end
            end else if (flush && (cnt != '0)) begin
               state_nxt = SEND;
               valid_nxt = 1'b1;
               for (int unsigned i = 0; i < BEATS; i++) begin
                  keep_nxt[i] = (CNT_W'(i) < cnt);
               end
            end
         end
         SEND: begin
            if (out_ready) begin
               // Clearing the data too keeps unused lanes zero for the next partial word.
               state_nxt = FILL;
               cnt_nxt   = '0;
               data_nxt  = '0;
               keep_nxt  = '0;
               valid_nxt = 1'b0;
            end
         end
         default: begin
            state_nxt = FILL;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge rclk) begin
      if (rrst) begin
         state     <= FILL;
         cnt       <= '0;
         pend      <= 1'b0;
         out_data  <= '0;
         out_keep  <= '0;
         out_valid <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         pend      <= rinc;
         out_data  <= data_nxt;
         out_keep  <= keep_nxt;
         out_valid <= valid_nxt;
      end
   end

endmodule : fifo_rd_packer

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer with a small FIFO read-port model.
module tb_fifo_rd_packer;

   logic        rclk = 1'b0;
   logic        rrst = 1'b1;
   logic        rempty;
   logic [7:0]  rdata = 8'h00;
   logic        rinc;
   logic        flush = 1'b0;
   logic [31:0] out_data;
   logic [3:0]  out_keep;
   logic        out_valid;
   logic        out_ready = 1'b0;

   logic [7:0]  mem [0:63];
   logic [5:0]  wr_ptr = 6'd0;
   logic [5:0]  rd_ptr = 6'd0;
   logic        gap = 1'b0;
   logic        rinc_s = 1'b0;

   int n_assert = 0;
   int n_fail   = 0;

   fifo_rd_packer #(.DATA_WIDTH(8), .BEATS(4)) dut (
      .rclk      (rclk),
      .rrst      (rrst),
      .rempty    (rempty),
      .rdata     (rdata),
      .rinc      (rinc),
      .flush     (flush),
      .out_data  (out_data),
      .out_keep  (out_keep),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 rclk = ~rclk;

   // FIFO looks empty when drained or when a gap is forced.
   assign rempty = gap || (rd_ptr == wr_ptr);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Sample the pop request mid-cycle, away from the clock edge.
   always @(negedge rclk) begin
      rinc_s = rinc;
      if (rinc) check("rinc_while_empty", 32'(rempty), 32'd0);
   end

   // Read data appears the cycle after a pop.
   always @(posedge rclk) begin
      if (rinc_s) begin
         rdata  <= mem[rd_ptr];
         rd_ptr <= rd_ptr + 6'd1;
      end
   end

   task automatic push(input logic [7:0] b);
      mem[wr_ptr] = b;
      wr_ptr = wr_ptr + 6'd1;
   endtask

   task automatic step();
      @(posedge rclk);
      #2;
   endtask

   task automatic wait_valid(input string tag, input int max_cycles);
      int k;
      k = 0;
      while (out_valid !== 1'b1 && k < max_cycles) begin
         step();
         k++;
      end
      check(tag, 32'(out_valid), 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset held for two cycles with data available.
      push(8'hEE);
      repeat (2) begin
         step();
         check("rst_rinc",  32'(rinc),      32'd0);
         check("rst_valid", 32'(out_valid), 32'd0);
         check("rst_data",  out_data,       32'd0);
      end
      check("rst_keep", 32'(out_keep), 32'd0);

      // Leftover byte gets popped and flushed as a single-lane word.
      rrst = 1'b0;
      #1;
      check("post_rst_rinc", 32'(rinc), 32'd1);
      step();
      step();
      flush = 1'b1;
      step();
      check("one_valid", 32'(out_valid), 32'd1);
      check("one_keep",  32'(out_keep),  32'h1);
      check("one_data",  out_data,       32'h0000_00EE);
      flush     = 1'b0;
      out_ready = 1'b1;
      step();
      check("one_accept_valid", 32'(out_valid), 32'd0);
      check("one_accept_keep",  32'(out_keep),  32'd0);

      // Full pack at one pop per cycle.
      push(8'h11); push(8'h22); push(8'h33); push(8'h44);
      #1;
      check("pack_rinc0", 32'(rinc), 32'd1);
      step(); check("pack_rinc1", 32'(rinc), 32'd1);
      step(); check("pack_rinc2", 32'(rinc), 32'd1);
      step(); check("pack_rinc3", 32'(rinc), 32'd1);
      step();
      check("pack_rinc_done", 32'(rinc),      32'd0);
      check("pack_not_yet",   32'(out_valid), 32'd0);
      step();
      check("pack_valid", 32'(out_valid), 32'd1);
      check("pack_data",  out_data,       32'h4433_2211);
      check("pack_keep",  32'(out_keep),  32'hF);
      step();
      check("pack_accept", 32'(out_valid), 32'd0);

      // Backpressure with more data waiting in the FIFO.
      out_ready = 1'b0;
      push(8'h55); push(8'h66); push(8'h77); push(8'h88);
      push(8'h91); push(8'h92); push(8'h93); push(8'h94);
      wait_valid("bp_valid", 10);
      for (int i = 0; i < 5; i++) begin
         check("bp_rinc",  32'(rinc),      32'd0);
         check("bp_hold",  out_data,       32'h8877_6655);
         check("bp_valid", 32'(out_valid), 32'd1);
         step();
      end
      check("bp_keep", 32'(out_keep), 32'hF);
      out_ready = 1'b1;
      step();
      check("bp_accept", 32'(out_valid), 32'd0);
      wait_valid("bp2_valid", 10);
      check("bp2_data", out_data,      32'h9493_9291);
      check("bp2_keep", 32'(out_keep), 32'hF);
      step();
      check("bp2_accept", 32'(out_valid), 32'd0);

      // Partial flush of two bytes.
      out_ready = 1'b0;
      push(8'hAA); push(8'hBB);
      repeat (4) step();
      check("pf_idle", 32'(out_valid), 32'd0);
      flush = 1'b1;
      step();
      check("pf_valid", 32'(out_valid), 32'd1);
      check("pf_data",  out_data,       32'h0000_BBAA);
      check("pf_keep",  32'(out_keep),  32'h3);
      flush     = 1'b0;
      out_ready = 1'b1;
      step();
      check("pf_accept", 32'(out_valid), 32'd0);

      // Flush with nothing captured produces no word.
      flush = 1'b1;
      repeat (3) begin
         step();
         check("idle_flush_valid", 32'(out_valid), 32'd0);
         check("idle_flush_rinc",  32'(rinc),      32'd0);
      end
      flush = 1'b0;

      // Empty gap in the middle of a word.
      push(8'h01); push(8'h02);
      repeat (4) step();
      gap = 1'b1;
      push(8'h03); push(8'h04);
      repeat (3) begin
         step();
         check("gap_rinc",  32'(rinc),      32'd0);
         check("gap_valid", 32'(out_valid), 32'd0);
      end
      gap = 1'b0;
      wait_valid("gap_word_valid", 10);
      check("gap_data", out_data,      32'h0403_0201);
      check("gap_keep", 32'(out_keep), 32'hF);
      step();
      check("gap_accept", 32'(out_valid), 32'd0);

      // Reset mid-word discards captured lanes.
      out_ready = 1'b0;
      push(8'hC1); push(8'hC2); push(8'hC3);
      step();
      step();
      rrst = 1'b1;
      step();
      check("midrst_rinc",  32'(rinc),      32'd0);
      check("midrst_valid", 32'(out_valid), 32'd0);
      check("midrst_data",  out_data,       32'd0);
      check("midrst_keep",  32'(out_keep),  32'd0);
      rrst  = 1'b0;
      gap   = 1'b1;
      flush = 1'b1;
      step();
      step();
      check("midrst_flush_ignored", 32'(out_valid), 32'd0);
      flush = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule : tb_fifo_rd_packer
